// File: rtl/mfm_wr_seq.sv
// -----------------------------------------------------------------------------
// mfm_wr_seq -- write-sector sequencer for the MFM encoder of the
// WD1793-compatible FDC core.
//
// Produces the sector data field and owns the encoder's WRITE GATE and its
// byte-feed handshake. The field is: sync 00s, A1 marks sent with clock-drop
// translation, the data address mark, the host data bytes, CRC-16 (CCITT,
// preset FFFF, MSB first) and the trailing gap.
//
// The byte preloaded into the encoder while WG is low (oBYTE = 00 in IDLE)
// counts as the first sync byte. Every later byte is handed over with a
// one-cycle oBYTE_2_WRITE acknowledge in reply to iNEXT_BYTE.
//
// Ports:
//   iCLK           16 MHz system clock
//   iRESETn        asynchronous active-low reset
//   iSTART         one-cycle pulse that starts a sector write (ignored if busy)
//   iLEN_CODE[1:0] sector length N = 128 << iLEN_CODE, sampled at iSTART
//   iMARK[7:0]     data address mark (FB normal, F8 deleted), sampled at iSTART
//   iDATA[7:0]     host data byte
//   iDAV           one-cycle strobe: iDATA is valid
//   iNEXT_BYTE     encoder request for the next byte (level)
//   iCRC_CORRUPT   (optional) invert the low CRC byte, sampled at iSTART
//   oBYTE[7:0]     byte presented to the encoder
//   oBYTE_2_WRITE  one-cycle acknowledge: oBYTE is valid
//   oTRANSLATE     A1/C2 clock-drop enable for the encoder
//   oWG            WRITE GATE
//   oDRQ           host data request
//   oLOST          sticky lost-data (underrun) flag
//   oBUSY          sequence in progress
//   oDONE          one-cycle pulse at the end of the sequence
//
// Build option:
//   MFM_WR_SEQ_CRC_CORRUPT_EN  adds iCRC_CORRUPT for exercising CRC error
//                              paths; undefined, the CRC is always sent true.
// -----------------------------------------------------------------------------
module mfm_wr_seq #(
    parameter int unsigned SYNC_LEN = 12,
    parameter int unsigned AM_LEN   = 3,
    parameter logic [7:0]  GAP_BYTE = 8'h4E,
    parameter int unsigned TAIL_LEN = 1
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iSTART,
    input  logic [1:0] iLEN_CODE,
    input  logic [7:0] iMARK,
    input  logic [7:0] iDATA,
    input  logic       iDAV,
    input  logic       iNEXT_BYTE,
`ifdef MFM_WR_SEQ_CRC_CORRUPT_EN
    input  logic       iCRC_CORRUPT,
`endif
    output logic [7:0] oBYTE,
    output logic       oBYTE_2_WRITE,
    output logic       oTRANSLATE,
    output logic       oWG,
    output logic       oDRQ,
    output logic       oLOST,
    output logic       oBUSY,
    output logic       oDONE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_AM,
        ST_MARK,
        ST_DATA,
        ST_CRC1,
        ST_CRC2,
        ST_TAIL
    } seqStateT;

    // Per-phase byte counts in the 11-bit counter domain. The preloaded
    // byte already covers one sync byte, so only SYNC_LEN-1 remain.
    localparam logic [10:0] SYNC_REM  = 11'(SYNC_LEN - 1);
    localparam logic [10:0] AM_CNT    = 11'(AM_LEN);
    localparam logic [10:0] TAIL_CNT  = 11'(TAIL_LEN);
    localparam logic [10:0] START_CNT = (SYNC_LEN > 1) ? SYNC_REM : AM_CNT;
    localparam seqStateT    START_ST  = (SYNC_LEN > 1) ? ST_SYNC : ST_AM;

    // CCITT x^16+x^12+x^5+1, one byte, MSB first.
    function automatic logic [15:0] crcStep(input logic [15:0] crcIn,
                                            input logic [7:0]  dataIn);
        logic [15:0] c;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ dataIn[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    seqStateT    state;
    seqStateT    stateNext;
    logic [10:0] cnt;           // bytes still to feed in the current phase
    logic [10:0] nextPhaseLen;  // count loaded when the current phase ends
    logic [7:0]  byteReg;
    logic        ackReg;
    logic        doneReg;
    logic        xlatReg;
    logic        lostReg;
    logic [7:0]  markReg;
    logic [1:0]  lenReg;
    logic [15:0] crcReg;
    logic [7:0]  holdByte;
    logic        holdFull;
    logic [10:0] dataLen;
    logic [7:0]  feedByte;
    logic        startAcc;
    logic        feedReq;
    logic        tailDone;
    logic        doFeed;
    logic        endSeq;
    logic        phaseLast;
    logic        crcFeed;
    logic        dataFeed;

`ifdef MFM_WR_SEQ_CRC_CORRUPT_EN
    logic corruptReg;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            corruptReg <= 1'b0;
        end else if (startAcc) begin
            corruptReg <= iCRC_CORRUPT;
        end
    end
`else
    logic corruptReg;
    assign corruptReg = 1'b0;
`endif

    assign dataLen   = 11'd128 << lenReg;
    assign startAcc  = iSTART && (state == ST_IDLE);
    // A request is served only if the previous cycle carried no
    // acknowledge, so one held request never yields two feeds.
    assign feedReq   = iNEXT_BYTE && !ackReg && (state != ST_IDLE);
    // After the last gap byte the counter sits at 0 in TAIL; the next
    // request closes the sequence instead of being fed.
    assign tailDone  = (state == ST_TAIL) && (cnt == 11'd0);
    assign doFeed    = feedReq && !tailDone;
    assign endSeq    = feedReq && tailDone;
    assign phaseLast = (cnt == 11'd1);
    assign dataFeed  = doFeed && (state == ST_DATA);
    assign crcFeed   = doFeed && ((state == ST_AM) || (state == ST_MARK) ||
                                  (state == ST_DATA));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= stateNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and the per-state byte to feed
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first; a path
        // that skips an assignment would otherwise infer a latch.
        stateNext    = state;
        nextPhaseLen = 11'd1;
        feedByte     = 8'h00;
        case (state)
            ST_IDLE: begin
                if (iSTART) stateNext = START_ST;
            end
            ST_SYNC: begin
                nextPhaseLen = AM_CNT;
                if (doFeed && phaseLast) stateNext = ST_AM;
            end
            ST_AM: begin
                feedByte = 8'hA1;
                if (doFeed && phaseLast) stateNext = ST_MARK;
            end
            ST_MARK: begin
                feedByte     = markReg;
                nextPhaseLen = dataLen;
                if (doFeed) stateNext = ST_DATA;
            end
            ST_DATA: begin
                // An empty holding register at feed time is an underrun.
                feedByte = holdFull ? holdByte : 8'h00;
                if (doFeed && phaseLast) stateNext = ST_CRC1;
            end
            ST_CRC1: begin
                feedByte = crcReg[15:8];
                if (doFeed) stateNext = ST_CRC2;
            end
            ST_CRC2: begin
                feedByte     = crcReg[7:0] ^ {8{corruptReg}};
                nextPhaseLen = TAIL_CNT;
                if (doFeed) stateNext = ST_TAIL;
            end
            ST_TAIL: begin
                feedByte = GAP_BYTE;
                if (endSeq) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: counter, feed register, CRC, flags and host holding register
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            // NOTE: the holding register and CRC are ordinary flops and are
            // cleared here so a restart after reset never sees stale data.
            cnt      <= '0;
            byteReg  <= 8'h00;
            ackReg   <= 1'b0;
            doneReg  <= 1'b0;
            xlatReg  <= 1'b0;
            lostReg  <= 1'b0;
            markReg  <= 8'h00;
            lenReg   <= 2'd0;
            crcReg   <= 16'h0000;
            holdByte <= 8'h00;
            holdFull <= 1'b0;
        end else begin
            ackReg  <= doFeed;
            doneReg <= endSeq;

            if (startAcc) begin
                cnt     <= START_CNT;
                byteReg <= 8'h00;
                markReg <= iMARK;
                lenReg  <= iLEN_CODE;
                crcReg  <= 16'hFFFF;
                xlatReg <= 1'b0;
                lostReg <= 1'b0;
            end else if (doFeed) begin
                byteReg <= feedByte;
                // TAIL runs its counter down to 0 and waits there.
                if (phaseLast && (state != ST_TAIL)) begin
                    cnt <= nextPhaseLen;
                end else begin
                    cnt <= cnt - 11'd1;
                end
                if (crcFeed) crcReg <= crcStep(crcReg, feedByte);
                // Translation covers the marks only; it is dropped on the
                // first data byte so A1/C2 data bytes go out as plain MFM.
                if (state == ST_AM) xlatReg <= 1'b1;
                if (dataFeed) begin
                    xlatReg <= 1'b0;
                    if (!holdFull) lostReg <= 1'b1;
                end
            end

            // A strobe coinciding with a data feed is stored after the feed
            // has taken the old byte, so the register stays full.
            if (iDAV) begin
                holdByte <= iDATA;
                holdFull <= 1'b1;
            end else if (startAcc || dataFeed) begin
                holdFull <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        oBYTE         = byteReg;
        oBYTE_2_WRITE = ackReg;
        oTRANSLATE    = xlatReg;
        oLOST         = lostReg;
        oDONE         = doneReg;
        // WG and BUSY follow the state register directly so an async reset
        // drops them without waiting for a clock.
        oBUSY         = (state != ST_IDLE);
        oWG           = (state != ST_IDLE);
        oDRQ          = 1'b0;
        case (state)
            ST_SYNC, ST_AM, ST_MARK, ST_DATA: oDRQ = ~holdFull;
            default:                          oDRQ = 1'b0;
        endcase
    end

endmodule

// File: doc/mfm_wr_seq.md
Name: mfm_wr_seq

Overview:
- Write-sector sequencer for the MFM encoder in the WD1793-compatible FDC core.
- Owns the encoder's WRITE GATE and byte-feed handshake. Emits the sector data field: sync zeros, three translated A1 marks, data address mark, host data bytes, CRC-16 and trailing gap.
- Sits between the host-side data register (DRQ/DAV handshake) and the encoder; driven by the command FSM through a start pulse.

Parameters:
- SYNC_LEN, 12, number of 8'h00 sync bytes, including the byte preloaded before WG rises.
- AM_LEN, 3, number of 8'hA1 address-mark bytes sent with translate.
- GAP_BYTE, 8'h4E, trailing gap fill value.
- TAIL_LEN, 1, number of trailing gap bytes (>=1). The last one may be truncated by less than one bit cell.

Ports:
- iCLK, in, 1, 16 MHz system clock.
- iRESETn, in, 1, asynchronous active-low reset.
- iSTART, in, 1, one-cycle pulse that begins a sector write; ignored while oBUSY=1.
- iLEN_CODE, in, 2, sector length N = 128 << iLEN_CODE (128/256/512/1024); sampled at iSTART.
- iMARK, in, 8, data mark byte (FB normal, F8 deleted); sampled at iSTART.
- iDATA, in, 8, host data byte.
- iDAV, in, 1, one-cycle strobe: iDATA is valid.
- iNEXT_BYTE, in, 1, encoder request for the next byte (level; held until acknowledged).
- oBYTE, out, 8, byte presented to the encoder.
- oBYTE_2_WRITE, out, 1, one-cycle acknowledge that oBYTE is valid.
- oTRANSLATE, out, 1, encoder A1/C2 clock-drop enable.
- oWG, out, 1, WRITE GATE to the encoder and drive.
- oDRQ, out, 1, host data request.
- oLOST, out, 1, sticky lost-data flag (underrun).
- oBUSY, out, 1, sequence in progress.
- oDONE, out, 1, one-cycle pulse at end of sequence.

Behaviour:
- Async reset state: all outputs 0 except oBYTE = 8'h00. FSM is IDLE; counters, holding register and CRC are cleared. Reset asserted mid-sequence drops oWG immediately.
- States: IDLE -> SYNC -> AM -> MARK -> DATA -> CRC1 -> CRC2 -> TAIL -> IDLE.
- IDLE:
  - oBYTE = 00 and oWG = 0, so the encoder preloads 00 while WG is low.
  - On iSTART: oBUSY = 1, oLOST cleared, oWG = 1 on the next cycle, oDRQ = 1, byte counter = SYNC_LEN-1 remaining. The preloaded byte counts as sync byte 1.
- Feed rule:
  - In every non-IDLE state, a cycle with iNEXT_BYTE = 1 and no acknowledge in the previous cycle drives the next byte on oBYTE and pulses oBYTE_2_WRITE for exactly one cycle.
  - oBYTE holds until the next feed.
  - At most one feed per iNEXT_BYTE assertion.
- Byte order:
  - remaining sync 00s
  - AM_LEN x A1
  - iMARK
  - N data bytes
  - CRC[15:8], then CRC[7:0]
  - TAIL_LEN x GAP_BYTE
- CRC:
  - CCITT polynomial x^16+x^12+x^5+1, MSB first.
  - Preset FFFF at iSTART.
  - Updated combinationally per fed byte over the A1s, the mark and the data bytes only.
  - Value after the 3 A1s is CDB4.
- oTRANSLATE:
  - Set when the first A1 is fed; cleared when the first data byte is fed.
  - Because of this window, data bytes equal to A1/C2 are never translated.
- Host side:
  - One-byte holding register with a full flag.
  - iDAV writes iDATA and sets full; oDRQ = ~full during the MARK and DATA states and from start.
  - A data feed takes the holding byte and clears full.
  - If full = 0 at a data feed: feed 00, set oLOST (sticky), keep counting.
  - iDAV and a feed in the same cycle: the feed takes the old byte; the new byte is then stored and full stays 1.
  - oDRQ = 0 after the last data byte is fed.
- End of sequence:
  - On the first iNEXT_BYTE after the last gap byte is fed: oWG = 0, oBUSY = 0, one-cycle oDONE, return to IDLE. No acknowledge is issued for this request.
- Total acknowledges = SYNC_LEN - 1 + AM_LEN + 1 + N + 2 + TAIL_LEN.
- Byte counter is 11 bits wide, which covers N = 1024.

Optional Feature:
- MFM_WR_SEQ_CRC_CORRUPT_EN:
  - Defined: adds input iCRC_CORRUPT (1 bit), sampled at iSTART. When it is sampled as 1, CRC[7:0] is fed bitwise-inverted, for test/debug of CRC error paths.
  - Undefined: the port is absent and the CRC is always fed true.

Test Plan:
- Reset with iLEN_CODE=0, iMARK=FB, host answers every oDRQ within 2 cycles -> 146 acknowledges. Byte stream: 11x00, A1 A1 A1, FB, 128 data bytes, CRC hi/lo, 4E. oLOST=0, oDONE pulses once, oWG low afterwards.
- Same run, monitoring CRC and oTRANSLATE -> CRC register = CDB4 after the third A1. oTRANSLATE high from the first A1 feed until the first data feed. Fed CRC equals the software CCITT model.
- Host withholds iDAV for data byte 5 -> byte 5 fed as 00, oLOST=1 and held, 128 data bytes still sent, CRC computed over 00.
- Data pattern containing A1 and C2 -> oTRANSLATE=0 during the data phase; the encoder output for these bytes is normal MFM.
- Assert iRESETn=0 during the DATA phase -> oWG, oBUSY and oDRQ go 0 asynchronously. A later iSTART restarts cleanly with oLOST=0.
- iSTART pulsed while oBUSY=1 -> ignored, stream unchanged. With MFM_WR_SEQ_CRC_CORRUPT_EN and iCRC_CORRUPT=1 -> low CRC byte = ~model.
